apb_timer: RTL and testbench
============================

# apb_timer

APB slave general-purpose timer, one of the peripherals on the APB side of the AHB-to-APB bridge. Occupies one 256-byte slave window, exposes a prescaled up-counter with compare match, a sticky status flag and a level interrupt. Zero-wait-state APB responder; the bridge's per-slave `pready`/`pslverr`/`prdata` lanes connect directly to this block.

## Interface
- `DATA_WIDTH`, 32: APB data width and counter/compare width.
- `PRESC_WIDTH`, 16: prescaler register width.
- `hclk_i`  in  1  clock; APB runs on the AHB clock.
- `hreset_i`  in  1  reset, synchronous, active-high.
- `psel_i`  in  1  slave select from bridge.
- `penable_i`  in  1  APB access phase.
- `pwrite_i`  in  1  1 = write, 0 = read.
- `paddr_i`  in  DATA_WIDTH  byte address; only `[7:0]` decoded.
- `pwdata_i`  in  DATA_WIDTH  write data.
- `prdata_o`  out  DATA_WIDTH  read data.
- `pready_o`  out  1  transfer ready.
- `pslverr_o`  out  1  transfer error.
- `irq_o`  out  1  level interrupt, registered.
- `pwm_o`  out  1  PWM output (see Configuration).

## Operation
- Register map (offset `paddr_i[7:0]`):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
  - 0x04 PRESC: `PRESC_WIDTH` bits; tick every PRESC+1 clocks.
  - 0x08 COUNT: counter value, read/write.
  - 0x0C COMPARE: match value.
  - 0x10 STATUS: bit0 MATCH, sticky; write 1 clears, write 0 no effect.
- Any other offset, or `paddr_i[1:0]` ≠ 0: invalid.
- Write commit: rising edge with `psel_i & penable_i & pwrite_i` and valid address.
- Invalid access: `pslverr_o`=1 in access phase; write ignored, read returns 0.
- Read: `prdata_o` = addressed register whenever `psel_i & !pwrite_i`, else 0.
- Prescaler: internal `presc_cnt`. While EN=1: if `presc_cnt`==PRESC → `presc_cnt`←0 and tick; else increment. EN=0: `presc_cnt` held at 0, no ticks.
- On tick:
  - COUNT==COMPARE → MATCH←1; then COUNT←0 if AUTORELOAD, else COUNT holds and EN←0 (one-shot).
  - Otherwise COUNT←COUNT+1, modulo 2^DATA_WIDTH (all-ones wraps to 0, no flag).
- `irq_o` ← MATCH & IRQEN, registered.

## Timing
- Reset (synchronous, `hreset_i`=1 at edge): CTRL, PRESC, COUNT, STATUS, `presc_cnt` = 0; COMPARE = all ones; `irq_o`=0, `pwm_o`=0. Reset overrides any concurrent APB write or tick.
- `pready_o` = `psel_i & penable_i` (zero wait states); 0 otherwise. `pslverr_o` only when `pready_o`=1.
- Write latency: register value visible on reads from the cycle after the commit edge.
- MATCH set at the tick edge; `irq_o` rises one clock later. Clearing MATCH drops `irq_o` one clock after the clear commits.
- Simultaneous events at one edge:
  - APB COUNT write + tick: write wins, `presc_cnt`←0.
  - STATUS clear + new match: set wins, MATCH stays 1.
  - CTRL write + one-shot auto-clear of EN: APB write wins.
- PRESC write while running: takes effect immediately; if `presc_cnt` > new PRESC, `presc_cnt`←0 at the same edge.
- PRESC=0: tick every enabled clock.

## Configuration
- `APB_TIMER_PWM_EN` defined:
  - `pwm_o` registered: 1 while COUNT < COMPARE and EN=1, else 0.
  - CTRL bit3 POL is implemented and inverts `pwm_o` when EN=1.
- Not defined:
  - `pwm_o` tied 0.
  - CTRL bit3 reads 0 and ignores writes.
  - No PWM logic is synthesized.

## Test plan
- Reset, then read all five registers → CTRL/PRESC/COUNT/STATUS=0, COMPARE=0xFFFF_FFFF, `pready_o`=1 and `pslverr_o`=0 on every read.
- PRESC=3, COMPARE=5, CTRL=0x7 → MATCH=1 after exactly 24 clocks from the CTRL commit; `irq_o` one clock later; COUNT returns to 0 and keeps counting.
- One-shot: PRESC=0, COMPARE=2, CTRL=0x1 → MATCH sets at third tick; EN reads 0 and COUNT holds at 2.
- Write 1 to STATUS on the same edge as a new match → MATCH stays 1 and `irq_o` stays 1; a later clear drops `irq_o` one clock after.
- Access offset 0x14 and offset 0x02 → `pslverr_o`=1 and read data 0; a write to offset 0x14 leaves every register unchanged.
- With `APB_TIMER_PWM_EN` defined: PRESC=0, COMPARE=4, CTRL=0x3 → `pwm_o` high 4 of every 5 clocks; same test with POL=1 → `pwm_o` inverted.

Source files
------------

// File: rtl/apb_timer.sv
// APB timer: prescaled up-counter with compare match, sticky MATCH flag and level irq.
// Optional PWM output and CTRL.POL bit are built only when APB_TIMER_PWM_EN is defined.
module apb_timer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  irq_o,
  output logic                  pwm_o
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_PRESC   = 8'h04;
  localparam logic [7:0] ADDR_COUNT   = 8'h08;
  localparam logic [7:0] ADDR_COMPARE = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;

  logic [7:0]             addr;
  logic                   access;
  logic                   addr_valid;
  logic                   wr_en;
  logic                   unused_addr;

  logic                   ctrl_en_q, ctrl_en_d;
  logic                   ctrl_ar_q, ctrl_ar_d;
  logic                   ctrl_irqen_q, ctrl_irqen_d;
  logic                   ctrl_pol_q;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [DATA_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]  compare_q, compare_d;
  logic                   match_q, match_d;
  logic                   irq_q, irq_d;
  logic                   tick;
  logic                   match_hit;

`ifdef APB_TIMER_PWM_EN
  logic                   ctrl_pol_d;
  logic                   pwm_q, pwm_d;
`else
  assign ctrl_pol_q = 1'b0;
`endif

  assign addr        = paddr_i[7:0];
  assign unused_addr = ^paddr_i[DATA_WIDTH-1:8];
  assign access      = psel_i & penable_i;
  assign wr_en       = access & pwrite_i & addr_valid;
  assign pready_o    = access;
  assign pslverr_o   = access & ~addr_valid;
  assign irq_o       = irq_q;

  // Address decode; misaligned offsets never match a register
  always_comb begin
    addr_valid = 1'b0;
    case (addr)
      ADDR_CTRL, ADDR_PRESC, ADDR_COUNT, ADDR_COMPARE, ADDR_STATUS: addr_valid = 1'b1;
      default: addr_valid = 1'b0;
    endcase
  end

  // Read mux, live during both setup and access phases of a read
  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i) begin
      case (addr)
        ADDR_CTRL:    prdata_o = DATA_WIDTH'({ctrl_pol_q, ctrl_irqen_q, ctrl_ar_q, ctrl_en_q});
        ADDR_PRESC:   prdata_o = DATA_WIDTH'(presc_q);
        ADDR_COUNT:   prdata_o = count_q;
        ADDR_COMPARE: prdata_o = compare_q;
        ADDR_STATUS:  prdata_o = DATA_WIDTH'(match_q);
        default:      prdata_o = '0;
      endcase
    end
  end

  // Next-state: prescaler and counter first, then APB writes override
  always_comb begin
    ctrl_en_d    = ctrl_en_q;
    ctrl_ar_d    = ctrl_ar_q;
    ctrl_irqen_d = ctrl_irqen_q;
    presc_d      = presc_q;
    presc_cnt_d  = presc_cnt_q;
    count_d      = count_q;
    compare_d    = compare_q;
    match_d      = match_q;
    tick         = ctrl_en_q && (presc_cnt_q == presc_q);
    match_hit    = tick && (count_q == compare_q);
`ifdef APB_TIMER_PWM_EN
    ctrl_pol_d   = ctrl_pol_q;
    pwm_d        = ctrl_en_q ? ((count_q < compare_q) ^ ctrl_pol_q) : 1'b0;
`endif

    if (!ctrl_en_q || tick) presc_cnt_d = '0;
    else                    presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);

    if (tick) begin
      if (match_hit) begin
        if (ctrl_ar_q) count_d   = '0;
        else           ctrl_en_d = 1'b0;
      end else begin
        count_d = count_q + DATA_WIDTH'(1);
      end
    end

    if (wr_en) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_en_d    = pwdata_i[0];
          ctrl_ar_d    = pwdata_i[1];
          ctrl_irqen_d = pwdata_i[2];
`ifdef APB_TIMER_PWM_EN
          ctrl_pol_d   = pwdata_i[3];
`endif
        end
        ADDR_PRESC: begin
          presc_d = pwdata_i[PRESC_WIDTH-1:0];
          // New period shorter than the running phase: restart the phase
          if (presc_cnt_d > pwdata_i[PRESC_WIDTH-1:0]) presc_cnt_d = '0;
        end
        ADDR_COUNT:   count_d   = pwdata_i;
        ADDR_COMPARE: compare_d = pwdata_i;
        ADDR_STATUS:  if (pwdata_i[0]) match_d = 1'b0;
        default: ;
      endcase
    end

    // A fresh match outranks a concurrent clear
    if (match_hit) match_d = 1'b1;

    irq_d = match_q & ctrl_irqen_q;
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      ctrl_en_q    <= 1'b0;
      ctrl_ar_q    <= 1'b0;
      ctrl_irqen_q <= 1'b0;
      presc_q      <= '0;
      presc_cnt_q  <= '0;
      count_q      <= '0;
      compare_q    <= '1;
      match_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      ctrl_ar_q    <= ctrl_ar_d;
      ctrl_irqen_q <= ctrl_irqen_d;
      presc_q      <= presc_d;
      presc_cnt_q  <= presc_cnt_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      match_q      <= match_d;
      irq_q        <= irq_d;
    end
  end

`ifdef APB_TIMER_PWM_EN
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      ctrl_pol_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      ctrl_pol_q <= ctrl_pol_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer; read expectations flow through a scoreboard queue.
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;
  logic        pwm;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic        is_read;
  } exp_t;

  exp_t sb_q[$];

  apb_timer #(.DATA_WIDTH(32), .PRESC_WIDTH(16)) dut (
    .hclk_i    (clk),
    .hreset_i  (rst),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .irq_o     (irq),
    .pwm_o     (pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; commit edge is the second posedge; returns at the negedge after it
  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic exp_err, input string tag);
    exp_t e;
    e.tag = tag; e.data = '0; e.err = exp_err; e.is_read = 1'b0;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {24'h0, addr}; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1;
    e = sb_q.pop_front();
    check({e.tag, " wr pready"}, 32'(pready), 32'd1);
    check({e.tag, " wr pslverr"}, 32'(pslverr), 32'(e.err));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  // Samples the state produced by the first posedge after the call
  task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
    exp_t e;
    e.tag = tag; e.data = exp_data; e.err = exp_err; e.is_read = 1'b1;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, addr};
    @(negedge clk);
    penable = 1'b1;
    #1;
    e = sb_q.pop_front();
    check({e.tag, " rdata"}, prdata, e.data);
    check({e.tag, " pready"}, 32'(pready), 32'd1);
    check({e.tag, " pslverr"}, 32'(pslverr), 32'(e.err));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; paddr = '0;
  endtask

  initial begin
    int n;
    int highs;

    // Reset state
    do_reset();
    check("idle pready", 32'(pready), 32'd0);
    check("idle prdata", prdata, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset pwm", 32'(pwm), 32'd0);
    apb_read(8'h00, 32'h0, 1'b0, "rst CTRL");
    apb_read(8'h04, 32'h0, 1'b0, "rst PRESC");
    apb_read(8'h08, 32'h0, 1'b0, "rst COUNT");
    apb_read(8'h0C, 32'hFFFF_FFFF, 1'b0, "rst COMPARE");
    apb_read(8'h10, 32'h0, 1'b0, "rst STATUS");

    // Periodic: tick every 4 clocks, match on the 6th tick = 24 clocks after CTRL commit
    do_reset();
    apb_write(8'h04, 32'd3, 1'b0, "per PRESC");
    apb_write(8'h0C, 32'd5, 1'b0, "per COMPARE");
    apb_write(8'h00, 32'h7, 1'b0, "per CTRL");
    n = 0;
    while (irq !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("irq latency clocks", 32'(n), 32'd25);
    apb_read(8'h10, 32'h1, 1'b0, "per STATUS");
    apb_read(8'h08, 32'h1, 1'b0, "per COUNT after reload");

    // Running counter: COUNT write beats tick, then all-ones wraps without a match
    do_reset();
    apb_write(8'h0C, 32'd1000, 1'b0, "wrap COMPARE");
    apb_write(8'h00, 32'h1, 1'b0, "wrap CTRL");
    apb_write(8'h08, 32'd100, 1'b0, "wr COUNT");
    apb_read(8'h08, 32'd101, 1'b0, "COUNT write wins");
    apb_write(8'h08, 32'hFFFF_FFFF, 1'b0, "wr COUNT max");
    apb_read(8'h08, 32'd0, 1'b0, "COUNT wrap");
    apb_read(8'h10, 32'h0, 1'b0, "no flag on wrap");

    // One-shot
    do_reset();
    apb_write(8'h0C, 32'd2, 1'b0, "os COMPARE");
    apb_write(8'h00, 32'h1, 1'b0, "os CTRL");
    repeat (5) @(negedge clk);
    apb_read(8'h00, 32'h0, 1'b0, "os EN cleared");
    apb_read(8'h08, 32'd2, 1'b0, "os COUNT held");
    apb_read(8'h10, 32'h1, 1'b0, "os STATUS");
    check("os irq masked", 32'(irq), 32'd0);

    // Clear coinciding with a match, then a clean clear
    do_reset();
    apb_write(8'h0C, 32'd2, 1'b0, "clr COMPARE");
    apb_write(8'h00, 32'h7, 1'b0, "clr CTRL");
    repeat (4) @(negedge clk);
    apb_write(8'h10, 32'h1, 1'b0, "clr on match");
    check("irq before clr edge", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq set wins", 32'(irq), 32'd1);
    @(negedge clk);
    apb_write(8'h10, 32'h1, 1'b0, "clr clean");
    check("irq same clk as clr", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq dropped", 32'(irq), 32'd0);

    // Invalid offsets
    do_reset();
    apb_write(8'h14, 32'hFFFF_FFFF, 1'b1, "inv wr 0x14");
    apb_write(8'h02, 32'hFFFF_FFFF, 1'b1, "inv wr 0x02");
    apb_read(8'h14, 32'h0, 1'b1, "inv rd 0x14");
    apb_read(8'h02, 32'h0, 1'b1, "inv rd 0x02");
    apb_read(8'h00, 32'h0, 1'b0, "inv CTRL");
    apb_read(8'h04, 32'h0, 1'b0, "inv PRESC");
    apb_read(8'h08, 32'h0, 1'b0, "inv COUNT");
    apb_read(8'h0C, 32'hFFFF_FFFF, 1'b0, "inv COMPARE");
    apb_read(8'h10, 32'h0, 1'b0, "inv STATUS");

    // Upper CTRL bits; bit3 only exists in the PWM build
    apb_write(8'h00, 32'hFFFF_FFF8, 1'b0, "ctrl hi");
`ifdef APB_TIMER_PWM_EN
    apb_read(8'h00, 32'h8, 1'b0, "ctrl POL");
`else
    apb_read(8'h00, 32'h0, 1'b0, "ctrl POL absent");
`endif
    check("pwm idle", 32'(pwm), 32'd0);

`ifdef APB_TIMER_PWM_EN
    do_reset();
    apb_write(8'h0C, 32'd4, 1'b0, "pwm COMPARE");
    apb_write(8'h00, 32'h3, 1'b0, "pwm CTRL");
    repeat (2) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm === 1'b1) highs++;
      @(negedge clk);
    end
    check("pwm duty", 32'(highs), 32'd8);
    apb_write(8'h00, 32'hB, 1'b0, "pwm POL");
    repeat (2) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm === 1'b1) highs++;
      @(negedge clk);
    end
    check("pwm duty inverted", 32'(highs), 32'd2);
`else
    do_reset();
    apb_write(8'h0C, 32'd4, 1'b0, "nopwm COMPARE");
    apb_write(8'h00, 32'h3, 1'b0, "nopwm CTRL");
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm !== 1'b0) highs++;
      @(negedge clk);
    end
    check("pwm tied low", 32'(highs), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
